uart_loop_fifo: RTL and testbench
=================================

# uart_loop_fifo

Byte buffer between the UART receiver and the UART transmitter in the loopback path. It captures every byte the receiver reports with its one-cycle done strobe into a small FIFO. It then replays the stored bytes to the transmitter one at a time, issuing a start pulse only when the transmitter is idle. This lets back-to-back received bytes survive while the transmitter is still shifting the previous byte out.

## Interface
- DEPTH, 16: FIFO entries; power of two, 2..256.
- ADDR_W, 4: log2(DEPTH).

- clk  in  1  system clock.
- rst  in  1  reset: asynchronous, active-high.
- rx_done  in  1  one-cycle strobe from the receiver; rx_data is valid in that cycle.
- rx_data  in  8  received byte.
- tx_busy  in  1  transmitter busy. High from the cycle after tx_en until the stop bit ends.
- tx_en  out  1  one-cycle start pulse to the transmitter.
- tx_data  out  8  byte to transmit; held stable from tx_en until the next launch.
- fifo_count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky flag: a byte was dropped because the FIFO was full.
- clr_ovf  in  1  synchronous clear of overflow.

## Operation
- Storage: DEPTH x 8 memory, wr_ptr/rd_ptr of ADDR_W bits, and an occupancy counter of ADDR_W+1 bits.
  - Pointers wrap modulo DEPTH with no special handling.
  - full = (count == DEPTH); empty = (count == 0).
- Write side:
  - When rx_done=1 and not full: mem[wr_ptr] <= rx_data and wr_ptr++.
  - When rx_done=1 and full: the byte is discarded, pointers are unchanged, and overflow <= 1.
  - Fullness is judged on the count before this edge. A read in the same cycle does not make room.
- Overflow flag:
  - clr_ovf=1 clears overflow.
  - If a drop and clr_ovf=1 occur in the same cycle, set wins and overflow stays 1.
- Read FSM, states IDLE, WAIT_ACK, WAIT_DONE:
  - IDLE: if !empty and !tx_busy, then:
    - tx_data <= mem[rd_ptr], rd_ptr++, tx_en <= 1.
    - Next state WAIT_ACK.
    - Otherwise stay in IDLE.
  - WAIT_ACK: tx_en <= 0. When tx_busy=1, go to WAIT_DONE; otherwise stay.
  - WAIT_DONE: when tx_busy=0, go to IDLE.
- Count update:
  - Simultaneous accepted write and launch: count unchanged.
  - Write only: +1. Launch only: -1.
  - Count never exceeds DEPTH and never wraps below 0.
- Data ordering: bytes leave in exactly the order accepted, with no duplication. Dropped bytes never appear.

## Timing
- Reset values (asserted asynchronously, held while rst=1):
  - tx_en=0, tx_data=8'h00, fifo_count=0, overflow=0.
  - Pointers 0, state IDLE.
  - Memory contents are don't-care.
- Reset mid-operation:
  - All buffered bytes are lost.
  - tx_en drops in the same instant as rst, with no pulse completion.
  - After rst falls, the block is idle and empty.
- Latency, with the FIFO empty and tx_busy=0:
  - rx_done sampled at edge n → fifo_count=1 after edge n.
  - tx_en=1 during cycle n+1..n+2 (set at edge n+1).
  - fifo_count returns to 0 after edge n+1.
- tx_en is exactly one clock wide and never asserted outside IDLE→WAIT_ACK. At most one launch per transmitter busy period.
- A new launch requires tx_busy to have risen and then fallen. The minimum gap between tx_en pulses is therefore one full transmitter frame plus one cycle.
- tx_data changes only on the launch edge.
- fifo_count and overflow are registered and update on the same edge as the pointer change.

## Test plan
- Single byte: rx_done with 8'hA5, transmitter model busy for 10 cycles → exactly one tx_en, one cycle after the write, with tx_data=8'hA5; fifo_count sequence 0→1→0.
- Burst: 5 bytes 8'h01..8'h05 on consecutive cycles while tx_busy is held high for a long time → fifo_count reaches 5. After busy drops, tx_en pulses emit 01,02,03,04,05 in order, one per busy period.
- Overflow: tx_busy held 1, 17 writes 8'h10..8'h20 → fifo_count=16, overflow=1, and byte 8'h20 is never transmitted. A later clr_ovf pulse gives overflow=0.
- Set-wins: a drop and clr_ovf in the same cycle → overflow=1.
- Simultaneous write and launch at count=1 → fifo_count stays 1, and the order is preserved across a pointer wrap (write 40 bytes through DEPTH=16 at matched rate).
- Reset mid-frame: assert rst while in WAIT_DONE with 3 bytes queued → all outputs at reset values immediately. After release, no tx_en until new rx_done.

Source files
------------

// File: rtl/uart_loop_fifo.sv
// Loopback byte buffer: queues every byte reported by the UART receiver and
// replays them in order to the transmitter, one launch per transmitter busy period.
module uart_loop_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_done,
   input  logic [7:0]        rx_data,
   input  logic              tx_busy,
   output logic              tx_en,
   output logic [7:0]        tx_data,
   output logic [ADDR_W:0]   fifo_count,
   output logic              overflow,
   input  logic              clr_ovf
);

   localparam logic [ADDR_W:0]   FULL_C   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1'b1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1'b1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_ACK  = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   logic [7:0]        mem_r [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_r;
   logic [ADDR_W-1:0] rd_ptr_r;
   logic [ADDR_W:0]   count_r;
   state_t            state_r;
   logic              tx_en_r;
   logic [7:0]        tx_data_r;
   logic              overflow_r;

   logic              full_s;
   logic              empty_s;
   logic              wr_s;
   logic              drop_s;
   logic              launch_s;

   // Occupancy flags and the accept/drop/launch decisions for this cycle.
   always_comb begin
      full_s   = (count_r == FULL_C);
      empty_s  = (count_r == {(ADDR_W+1){1'b0}});
      wr_s     = rx_done & ~full_s;
      drop_s   = rx_done & full_s;
      launch_s = (state_r == IDLE) & ~empty_s & ~tx_busy;
   end

   // Storage array; contents are don't-care after reset, so it carries none.
   always_ff @(posedge clk) begin
      if (wr_s) begin
         mem_r[wr_ptr_r] <= rx_data;
      end
   end

   // Write pointer and occupancy; a same-cycle write and launch cancel out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {ADDR_W{1'b0}};
         count_r  <= {(ADDR_W+1){1'b0}};
      end else begin
         if (wr_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         case ({wr_s, launch_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_r <= 1'b0;
      end else if (drop_s) begin
         overflow_r <= 1'b1;
      end else if (clr_ovf) begin
         overflow_r <= 1'b0;
      end else begin
         overflow_r <= overflow_r;
      end
   end

   // Launch FSM: waits for busy to rise and then fall before the next pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         rd_ptr_r  <= {ADDR_W{1'b0}};
         tx_en_r   <= 1'b0;
         tx_data_r <= 8'h00;
      end else begin
         case (state_r)
            IDLE: begin
               if (launch_s) begin
                  tx_data_r <= mem_r[rd_ptr_r];
                  rd_ptr_r  <= rd_ptr_r + PTR_ONE;
                  tx_en_r   <= 1'b1;
                  state_r   <= WAIT_ACK;
               end else begin
                  tx_en_r   <= 1'b0;
               end
            end
            WAIT_ACK: begin
               tx_en_r <= 1'b0;
               if (tx_busy) begin
                  state_r <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               tx_en_r <= 1'b0;
               if (!tx_busy) begin
                  state_r <= IDLE;
               end
            end
            default: begin
               tx_en_r <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign tx_en      = tx_en_r;
   assign tx_data    = tx_data_r;
   assign fifo_count = count_r;
   assign overflow   = overflow_r;

endmodule

// File: tb/tb_uart_loop_fifo.sv
// Bench for uart_loop_fifo: a transmitter model, a byte scoreboard, a vector
// table for the single-byte latency case and directed multi-cycle sequences.
module tb_uart_loop_fifo;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              rx_done = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              clr_ovf = 1'b0;
   logic              force_busy = 1'b0;
   logic              tx_busy;
   logic              tx_en;
   logic [7:0]        tx_data;
   logic [ADDR_W:0]   fifo_count;
   logic              overflow;

   int checks = 0;
   int failures = 0;
   int busy_len = 10;
   int busy_cnt = 0;
   int launches = 0;
   int l0 = 0;

   logic [7:0] sb_q[$];
   logic       exp_ovf = 1'b0;
   logic       prev_en = 1'b0;
   logic [7:0] last_data = 8'h00;

   typedef struct {
      logic       rxd;
      logic [7:0] data;
      logic       clr;
      logic       en;
      logic [7:0] txd;
      logic [4:0] cnt;
      logic       ovf;
   } vec_t;
   vec_t tbl[6];

   uart_loop_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data),
      .tx_busy(tx_busy), .tx_en(tx_en), .tx_data(tx_data),
      .fifo_count(fifo_count), .overflow(overflow), .clr_ovf(clr_ovf)
   );

   always #5 clk = ~clk;

   assign tx_busy = force_busy | (busy_cnt != 0);

   // Transmitter model: busy from the cycle after tx_en for busy_len cycles.
   always @(posedge clk or posedge rst) begin
      if (rst) busy_cnt <= 0;
      else if (tx_en) busy_cnt <= busy_len;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every launch, tracks count and overflow.
   always @(posedge clk) begin
      #1;
      if (!rst) begin
         if (tx_en) begin
            launches++;
            check("tx_en_width", 32'(prev_en), 0);
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL tx_unexpected: launch of 0x%0h with empty scoreboard at %0t", tx_data, $time);
            end else begin
               check("tx_data", 32'(tx_data), 32'(sb_q.pop_front()));
            end
         end else begin
            check("tx_data_hold", 32'(tx_data), 32'(last_data));
         end
         check("fifo_count", 32'(fifo_count), sb_q.size());
         check("overflow", 32'(overflow), 32'(exp_ovf));
         prev_en   = tx_en;
         last_data = tx_data;
      end
   end

   // Called at a negedge; applies one cycle of input and ends at the next negedge.
   task automatic drive(input logic d, input logic [7:0] b, input logic c);
      logic drop;
      drop = 1'b0;
      rx_done = d;
      rx_data = b;
      clr_ovf = c;
      if (d) begin
         if (sb_q.size() < DEPTH) sb_q.push_back(b);
         else drop = 1'b1;
      end
      if (drop) exp_ovf = 1'b1;
      else if (c) exp_ovf = 1'b0;
      @(negedge clk);
      rx_done = 1'b0;
      clr_ovf = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      while (tx_busy && n < 1000) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      checks++;
      if (sb_q.size() != 0 || tx_busy) begin
         failures++;
         $display("FAIL %s_drain: %0d bytes still pending, busy=%0b after budget", name, sb_q.size(), tx_busy);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0};
      tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b0};
      tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b0};
      tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b0};
      tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b0};
      tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b0};

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_tx_en", 32'(tx_en), 0);
      check("rst_tx_data", 32'(tx_data), 0);
      check("rst_count", 32'(fifo_count), 0);
      check("rst_ovf", 32'(overflow), 0);
      rst = 1'b0;
      idle(2);

      // Single byte latency through the vector table.
      busy_len = 10;
      l0 = launches;
      for (int i = 0; i < 6; i++) begin
         drive(tbl[i].rxd, tbl[i].data, tbl[i].clr);
         check($sformatf("vec%0d_tx_en", i), 32'(tx_en), 32'(tbl[i].en));
         check($sformatf("vec%0d_tx_data", i), 32'(tx_data), 32'(tbl[i].txd));
         check($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(tbl[i].cnt));
         check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
      end
      drain("single");
      check("single_launches", launches - l0, 1);

      // Burst of five while the transmitter is held busy.
      force_busy = 1'b1;
      l0 = launches;
      for (int i = 1; i <= 5; i++) drive(1'b1, 8'(i), 1'b0);
      check("burst_count", 32'(fifo_count), 5);
      check("burst_no_launch", launches - l0, 0);
      force_busy = 1'b0;
      drain("burst");
      check("burst_launches", launches - l0, 5);

      // Overflow, set-wins, then clear.
      force_busy = 1'b1;
      l0 = launches;
      for (int i = 0; i < 17; i++) drive(1'b1, 8'(8'h10 + i), 1'b0);
      check("ovf_count", 32'(fifo_count), 16);
      check("ovf_flag", 32'(overflow), 1);
      drive(1'b1, 8'h99, 1'b1);
      check("set_wins_ovf", 32'(overflow), 1);
      check("set_wins_count", 32'(fifo_count), 16);
      drive(1'b0, 8'h00, 1'b1);
      check("clr_ovf", 32'(overflow), 0);
      force_busy = 1'b0;
      drain("ovf");
      check("ovf_launches", launches - l0, 16);

      // Simultaneous write and launch at count 1, then 40 bytes across the wrap.
      busy_len = 2;
      force_busy = 1'b1;
      l0 = launches;
      drive(1'b1, 8'h30, 1'b0);
      check("simul_pre_count", 32'(fifo_count), 1);
      force_busy = 1'b0;
      drive(1'b1, 8'h31, 1'b0);
      check("simul_count", 32'(fifo_count), 1);
      check("simul_tx_en", 32'(tx_en), 1);
      check("simul_tx_data", 32'(tx_data), 32'h30);
      for (int i = 0; i < 40; i++) begin
         drive(1'b1, 8'(8'h40 + i), 1'b0);
         idle(5);
      end
      drain("wrap");
      check("wrap_launches", launches - l0, 42);

      // Reset while in WAIT_DONE with three bytes queued.
      busy_len = 20;
      for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h50 + i), 1'b0);
      idle(2);
      check("pre_rst_count", 32'(fifo_count), 3);
      #2;
      rst = 1'b1;
      sb_q.delete();
      exp_ovf = 1'b0;
      prev_en = 1'b0;
      last_data = 8'h00;
      #1;
      check("mid_rst_tx_en", 32'(tx_en), 0);
      check("mid_rst_tx_data", 32'(tx_data), 0);
      check("mid_rst_count", 32'(fifo_count), 0);
      check("mid_rst_ovf", 32'(overflow), 0);
      @(negedge clk);
      rst = 1'b0;
      l0 = launches;
      idle(20);
      check("post_rst_launches", launches - l0, 0);
      check("post_rst_count", 32'(fifo_count), 0);
      busy_len = 3;
      drive(1'b1, 8'h77, 1'b0);
      drain("post_rst");
      check("post_rst_new_launch", launches - l0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
